// File: rtl/actmem_gather_if.sv
// Bus bundle between the interleaver/testbench side and the activation-memory
// gather stage.
//   master : drives start, stall, memory_index_package and the write port;
//            observes cycle_index and the output package/status.
//   slave  : the gather stage itself.
// Lane i address occupies memory_index_package[AW*(i+1)-1 : AW*i].
// Lane i activation occupies act_package[BW*(i+1)-1 : BW*i].
interface actmem_gather_if #(
  parameter int P  = 32,
  parameter int Z  = 8,
  parameter int FO = 2,
  parameter int BW = 16
);
  localparam int N  = FO * P / Z;
  localparam int CW = $clog2(N);
  localparam int AW = $clog2(P);

  logic              start;
  logic              stall;
  logic [CW-1:0]     cycle_index;
  logic [AW*Z-1:0]   memory_index_package;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [BW-1:0]     wr_data;
  logic [BW*Z-1:0]   act_package;
  logic              act_valid;
  logic              done;
  logic              busy;
  logic              lane_err;

  modport master (
    output start, stall, memory_index_package, wr_en, wr_addr, wr_data,
    input  cycle_index, act_package, act_valid, done, busy, lane_err
  );

  modport slave (
    input  start, stall, memory_index_package, wr_en, wr_addr, wr_data,
    output cycle_index, act_package, act_valid, done, busy, lane_err
  );
endinterface

// File: rtl/actmem_gather.sv
// Activation-memory gather stage.
// Holds the left-hand activation memory as Z banks of P/Z rows. Neuron a sits
// in bank a mod Z at row a/Z. Each RUN cycle the combinational interleaver
// returns one address per lane for the current cycle_index; every lane reads
// its own bank asynchronously and the Z results are registered as one package.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : actmem_gather_if.slave (start/stall, cycle_index out,
//            interleaver addresses in, write port, package/status out)
// Assumes Z >= 2 and P > Z so the bank-select and row fields are non-empty.

// One bank plus its lane-local address check.
module actmem_gather_lane #(
  parameter int P    = 32,
  parameter int Z    = 8,
  parameter int BW   = 16,
  parameter int LANE = 0
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [$clog2(P/Z)-1:0] wr_row_i,
  input  logic [BW-1:0]         wr_data_i,
  input  logic [$clog2(P)-1:0]  rd_addr_i,
  output logic [BW-1:0]         rd_data_o,
  output logic                  addr_err_o
);
  localparam int ROWS = P / Z;
  localparam int AW   = $clog2(P);
  localparam int ZB   = $clog2(Z);

  logic [BW-1:0] mem_q [ROWS];

  // Contents survive reset on purpose: activations are reloaded by the host.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_row_i] <= wr_data_i;
  end

  // Asynchronous read; a same-edge write lands after the package captures it,
  // so a colliding read returns the old value.
  assign rd_data_o  = mem_q[rd_addr_i[AW-1:ZB]];
  assign addr_err_o = (rd_addr_i[ZB-1:0] != ZB'(LANE));
endmodule

module actmem_gather #(
  parameter int P  = 32,
  parameter int Z  = 8,
  parameter int FO = 2,
  parameter int BW = 16
) (
  input  logic           clk,
  input  logic           reset,
  actmem_gather_if.slave bus
);
  localparam int N  = FO * P / Z;
  localparam int CW = $clog2(N);
  localparam int AW = $clog2(P);
  localparam int ZB = $clog2(Z);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [Z-1:0][BW-1:0] pkg_q, pkg_d;
  logic                 vld_q, vld_d;
  logic                 err_q, err_d;

  logic [Z-1:0][BW-1:0] rd_data;
  logic [Z-1:0]         lane_bad;

  for (genvar g = 0; g < Z; g++) begin : g_lane
    actmem_gather_lane #(.P(P), .Z(Z), .BW(BW), .LANE(g)) u_lane (
      .clk        (clk),
      .wr_en_i    (bus.wr_en && (bus.wr_addr[ZB-1:0] == ZB'(g))),
      .wr_row_i   (bus.wr_addr[AW-1:ZB]),
      .wr_data_i  (bus.wr_data),
      .rd_addr_i  (bus.memory_index_package[AW*g +: AW]),
      .rd_data_o  (rd_data[g]),
      .addr_err_o (lane_bad[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pkg_d   = pkg_q;
    vld_d   = vld_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        vld_d = 1'b0;
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        if (!bus.stall) begin
          pkg_d = rd_data;
          vld_d = 1'b1;
          if (|lane_bad) err_d = 1'b1;
          // Terminal compare stops the counter at N-1; it never wraps.
          if (cnt_q == CW'(N - 1)) state_d = S_DRAIN;
          else                     cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // The last package is on the outputs during this cycle; leaving
        // returns the counter to 0 so IDLE presents cycle_index 0.
        if (!bus.stall) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pkg_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pkg_q   <= pkg_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign bus.cycle_index = cnt_q;
  assign bus.act_package = pkg_q;
  assign bus.act_valid   = vld_q;
  // done marks the DRAIN cycle that actually retires; a stall pushes it out.
  assign bus.done        = (state_q == S_DRAIN) && !bus.stall;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.lane_err    = err_q;
endmodule
